// File: rtl/array_window_accum.sv
// array_window_accum: running sum over the most recent DEPTH unsigned samples.
// Samples live in a circular array; once the window is full, each new sample
// displaces the oldest one, whose value is subtracted from the sum.
// Optional feature: define ARRAY_WINDOW_AVG_EN to add avg_out, the window
// mean (sum_out >> LOG2D), registered alongside sum_out.
module array_window_accum #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int LOG2D = $clog2(DEPTH),
    localparam int SW = WIDTH + LOG2D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic [SW-1:0]    sum_out,
    output logic [LOG2D:0]   count,
    output logic             full,
    output logic             out_valid,
`ifdef ARRAY_WINDOW_AVG_EN
    output logic [WIDTH-1:0] avg_out,
`endif
    output logic [WIDTH-1:0] evict_out
);

    typedef enum logic {
        FILL,
        STEADY
    } state_t;

    localparam logic [LOG2D:0] FULL_COUNT = (LOG2D + 1)'(DEPTH);

    state_t           state;
    logic [LOG2D-1:0] wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] old_sample;
    logic [SW-1:0]    sum_next;
    logic             accept;

    // A sample is taken only when clear is not flushing the window this cycle.
    assign accept     = in_valid && !clear;
    assign old_sample = mem[wr_ptr];

    // Next window sum; once the window is full the entry being overwritten
    // leaves the sum in the same cycle the new sample enters it. The
    // intermediate addition may wrap, but the true result always fits SW bits.
    always_comb begin
        sum_next = sum_out + SW'(data_in);
        if (state == STEADY) begin
            sum_next = sum_out + SW'(data_in) - SW'(old_sample);
        end
    end

    // Sample storage; never reset because stale entries are only read after
    // they have been rewritten in the current window.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Window control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_ptr    <= '0;
            count     <= '0;
            sum_out   <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            evict_out <= '0;
`ifdef ARRAY_WINDOW_AVG_EN
            avg_out   <= '0;
`endif
        end else if (clear) begin
            state     <= FILL;
            wr_ptr    <= '0;
            count     <= '0;
            sum_out   <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            evict_out <= '0;
`ifdef ARRAY_WINDOW_AVG_EN
            avg_out   <= '0;
`endif
        end else if (in_valid) begin
            wr_ptr    <= wr_ptr + 1'b1;
            sum_out   <= sum_next;
            out_valid <= 1'b1;
`ifdef ARRAY_WINDOW_AVG_EN
            avg_out   <= sum_next[SW-1:LOG2D];
`endif
            case (state)
                FILL: begin
                    count     <= count + 1'b1;
                    evict_out <= '0;
                    if (count == FULL_COUNT - 1'b1) begin
                        state <= STEADY;
                        full  <= 1'b1;
                    end
                end
                STEADY: begin
                    evict_out <= old_sample;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/array_window_accum.md
ARRAY_WINDOW_ACCUM -- requirements
Module: array_window_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 8, window length in samples (power of two, 2..256); LOG2D = log2(DEPTH); SW = WIDTH+LOG2D.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous flush of window, sum and count.
REQ-006 SHALL have port in_valid  input  1  data_in is accepted this cycle.
REQ-007 SHALL have port data_in  input  WIDTH  unsigned sample.
REQ-008 SHALL have port sum_out  output  SW  registered unsigned sum of samples currently in window.
REQ-009 SHALL have port count  output  LOG2D+1  registered number of samples in window, 0..DEPTH.
REQ-010 SHALL have port full  output  1  registered, high when count==DEPTH.
REQ-011 SHALL have port out_valid  output  1  registered one-cycle pulse after each accepted sample.
REQ-012 SHALL have port evict_out  output  WIDTH  registered sample displaced by last accepted sample; 0 if none displaced.

Function
REQ-013 SHALL store samples in a DEPTH-entry circular array with write pointer wr_ptr (LOG2D bits) wrapping DEPTH-1 -> 0 without extra logic.
REQ-014 SHALL implement two states: FILL (count<DEPTH) and STEADY (count==DEPTH); full mirrors STEADY.
REQ-015 On in_valid in FILL: array[wr_ptr]<=data_in, wr_ptr+1, count+1, sum+data_in, evict_out<=0; FILL->STEADY when count reaches DEPTH.
REQ-016 On in_valid in STEADY: array[wr_ptr]<=data_in, wr_ptr+1, count unchanged, sum <= sum + data_in - array[wr_ptr], evict_out<=array[wr_ptr].
REQ-017 sum_out SHALL never overflow or wrap: SW bits hold DEPTH*(2^WIDTH-1); subtraction uses old entry read in the same cycle.
REQ-018 out_valid SHALL be high exactly the cycle after an accepted sample (clear excluded) and low otherwise; latency from data_in to sum_out = 1 cycle.
REQ-019 in_valid low: all state and outputs hold, out_valid=0.
REQ-020 clear SHALL take priority over in_valid: same-cycle sample dropped; next cycle wr_ptr=0, count=0, sum_out=0, evict_out=0, full=0, out_valid=0, state FILL.
REQ-021 Array contents need not be cleared; stale entries SHALL never affect sum_out (only written entries are subtracted).

Reset
REQ-022 rst SHALL immediately force wr_ptr=0, count=0, sum_out=0, evict_out=0, full=0, out_valid=0, state FILL, independent of clk.
REQ-023 rst asserted mid-operation SHALL discard the window; first sample after deassertion behaves as first sample after clear.
REQ-024 Array storage SHALL not require reset.

Configuration
REQ-025 Macro ARRAY_WINDOW_AVG_EN defined: SHALL add output avg_out  output  WIDTH  = sum_out >> LOG2D, registered with sum_out, reset 0.
REQ-026 Macro undefined: avg_out port SHALL not exist and no averaging logic is built; all other behaviour identical.

Verification (WIDTH=8, DEPTH=4)
REQ-027 Reset, then samples 10,20,30,40 on consecutive cycles -> sum_out 10,30,60,100; count 1..4; full high after 4th; evict_out 0 throughout.
REQ-028 Continue with 50 -> sum_out 140, evict_out 10, count 4; then 60 -> sum_out 180, evict_out 20.
REQ-029 Feed 255 x 6 -> sum_out 1020 (max, no wrap), full=1; with ARRAY_WINDOW_AVG_EN avg_out=255.
REQ-030 In STEADY assert clear with in_valid=1, data_in=99 -> next cycle sum_out 0, count 0, full 0, out_valid 0; then 7 -> sum_out 7, evict_out 0.
REQ-031 Samples 1,2 with in_valid gap of 3 idle cycles between -> outputs hold during gap, out_valid pulses exactly twice, sum_out 3.
REQ-032 Assert rst asynchronously mid-cycle with count 3 -> outputs 0 before next clk edge; after release, 5 -> sum_out 5, count 1.
